// File: rtl/hack_pkg.sv
// -----------------------------------------------------------------------------
// hack_pkg
// Shared definitions for the data-memory loader.
//   state_t          : loader FSM state encoding
//   RAM_TOP_DEFAULT  : highest writable data-memory address
// -----------------------------------------------------------------------------
package hack_pkg;

    localparam logic [14:0] RAM_TOP_DEFAULT = 15'd16383;

    typedef enum logic [2:0] {
        IDLE,
        HI_BYTE,
        LO_BYTE,
        WRITE,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
// Streams big-endian byte pairs into 16-bit words and writes them to
// consecutive data-memory addresses starting at base_addr.
//
// Optional build macro: MEM_LOADER_READBACK_EN
//   When defined, every write is followed by a CHECK cycle that compares the
//   memory's combinational read data against the written word; a mismatch
//   sets error and ends the load.
//
// Ports
//   CLK, RST_N   : clock (rising edge), asynchronous active-low reset
//   start        : begin a load (sampled in IDLE only)
//   base_addr    : first target address, captured on accepted start
//   word_count   : number of words to load, captured on accepted start
//   byte_in      : stream byte; byte_valid/byte_ready handshake
//   mem_in       : write data to the memory
//   mem_address  : memory address (0 while idle)
//   mem_load     : memory write enable, one cycle per word
//   mem_out      : memory read data (readback builds only)
//   busy, done, error : status; error is sticky until the next start
// -----------------------------------------------------------------------------
module mem_loader
    import hack_pkg::*;
#(
    parameter logic [14:0] RAM_TOP = RAM_TOP_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic [14:0] base_addr,
    input  logic [14:0] word_count,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] mem_in,
    output logic [14:0] mem_address,
    output logic        mem_load,
    input  logic [15:0] mem_out,
    output logic        busy,
    output logic        done,
    output logic        error
);

    state_t      state_q, state_d;
    logic [14:0] addr_q,  addr_d;
    logic [14:0] rem_q,   rem_d;
    logic [15:0] word_q,  word_d;
    logic        err_q,   err_d;

    // Last address of the requested range, computed wide so it cannot wrap.
    logic [16:0] end_addr;
    assign end_addr = {2'b00, base_addr} + {2'b00, word_count} - 17'd1;

    // Shared post-write step: advance address and decide whether we are done.
    logic [14:0] addr_next;
    logic [14:0] rem_next;
    logic        last_word;
    assign addr_next = addr_q + 15'd1;
    assign rem_next  = rem_q - 15'd1;
    assign last_word = (rem_q == 15'd1);

`ifndef MEM_LOADER_READBACK_EN
    logic unused_mem_out;
    assign unused_mem_out = ^mem_out;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        word_d  = word_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d  = 1'b0;
                    addr_d = base_addr;
                    rem_d  = word_count;
                    if (word_count == '0) begin
                        state_d = DONE;
                    end else if (end_addr > {2'b00, RAM_TOP}) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = HI_BYTE;
                    end
                end
            end

            HI_BYTE: begin
                if (byte_valid) begin
                    word_d[15:8] = byte_in;
                    state_d      = LO_BYTE;
                end
            end

            LO_BYTE: begin
                if (byte_valid) begin
                    word_d[7:0] = byte_in;
                    state_d     = WRITE;
                end
            end

            WRITE: begin
`ifdef MEM_LOADER_READBACK_EN
                state_d = CHECK;
`else
                addr_d  = addr_next;
                rem_d   = rem_next;
                state_d = last_word ? DONE : HI_BYTE;
`endif
            end

            CHECK: begin
`ifdef MEM_LOADER_READBACK_EN
                if (mem_out != word_q) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    addr_d  = addr_next;
                    rem_d   = rem_next;
                    state_d = last_word ? DONE : HI_BYTE;
                end
`else
                state_d = IDLE;
`endif
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign byte_ready  = (state_q == HI_BYTE) || (state_q == LO_BYTE);
    assign mem_load    = (state_q == WRITE);
    assign mem_address = (state_q == IDLE) ? '0 : addr_q;
    assign mem_in      = word_q;
    assign error       = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mem_loader
// Table-driven directed bench for mem_loader plus hand sequences for
// mid-load reset and (in readback builds) readback mismatch.
// -----------------------------------------------------------------------------
module tb_mem_loader;

    logic        CLK;
    logic        RST_N;
    logic        start;
    logic [14:0] base_addr;
    logic [14:0] word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] mem_in;
    logic [14:0] mem_address;
    logic        mem_load;
    logic [15:0] mem_out;
    logic        busy;
    logic        done;
    logic        error;

    int checks;
    int failures;

    mem_loader #(.RAM_TOP(15'd16383)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_in     (mem_in),
        .mem_address(mem_address),
        .mem_load   (mem_load),
        .mem_out    (mem_out),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory model with combinational read and an optional corrupted address.
    logic [15:0] tb_mem [0:32767];
    logic        corrupt_en;
    logic [14:0] corrupt_addr;

    always @(posedge CLK) begin
        if (mem_load) tb_mem[mem_address] <= mem_in;
    end

    assign mem_out = tb_mem[mem_address] ^
                     ((corrupt_en && (mem_address == corrupt_addr)) ? 16'h8000 : 16'h0000);

    // Write monitor: mem_load is sampled once per cycle on the falling edge.
    logic [14:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];

    always @(negedge CLK) begin
        if (RST_N && mem_load) begin
            wr_addr_q.push_back(mem_address);
            wr_data_q.push_back(mem_in);
        end
    end

    typedef struct {
        logic [14:0] base;
        logic [14:0] count;
        logic [31:0] bytes;
        int unsigned gap;
        bit          mid_start;
        bit          exp_err;
        int unsigned exp_n;
        logic [15:0] exp_d0;
        logic [15:0] exp_d1;
    } vec_t;

    localparam int unsigned NVEC = 9;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic feed_byte(input logic [7:0] b, input bit pulse_start);
        int unsigned t;
        t = 0;
        while (!byte_ready && t < 20) begin
            @(negedge CLK);
            t++;
        end
        check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
        byte_in    = b;
        byte_valid = 1'b1;
        if (pulse_start) begin
            start      = 1'b1;
            base_addr  = 15'd5;
            word_count = 15'd1;
        end
        @(negedge CLK);
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic wait_done();
        int unsigned t;
        t = 0;
        while (!done && t < 40) begin
            @(negedge CLK);
            t++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        @(negedge CLK);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        bit immediate;
        int unsigned nbytes;
        wr_addr_q.delete();
        wr_data_q.delete();
        immediate = (v.count == 15'd0) || v.exp_err;
        nbytes    = 2 * int'(v.count);

        base_addr  = v.base;
        word_count = v.count;
        start      = 1'b1;
        @(negedge CLK);
        start      = 1'b0;

        if (immediate) begin
            check("done_after_start", {31'd0, done}, 32'd1);
            check("no_ready", {31'd0, byte_ready}, 32'd0);
            @(negedge CLK);
            check("done_one_cycle", {31'd0, done}, 32'd0);
            check("idle_after_done", {31'd0, busy}, 32'd0);
        end else begin
            check("busy_after_start", {31'd0, busy}, 32'd1);
            for (int k = 0; k < int'(nbytes); k++) begin
                feed_byte(v.bytes[31 - 8*k -: 8], v.mid_start && (k == 1));
                if (v.gap != 0 && (k % 2) == 0) begin
                    for (int g = 0; g < int'(v.gap); g++) begin
                        check("ready_held_in_gap", {31'd0, byte_ready}, 32'd1);
                        @(negedge CLK);
                    end
                end
            end
            wait_done();
        end

        check("error", {31'd0, error}, {31'd0, v.exp_err});
        check("write_count", wr_addr_q.size(), v.exp_n);
        if (v.exp_n >= 1 && wr_addr_q.size() >= 1) begin
            check("wr0_addr", {17'd0, wr_addr_q[0]}, {17'd0, v.base});
            check("wr0_data", {16'd0, wr_data_q[0]}, {16'd0, v.exp_d0});
        end
        if (v.exp_n >= 2 && wr_addr_q.size() >= 2) begin
            check("wr1_addr", {17'd0, wr_addr_q[1]}, {17'd0, v.base + 15'd1});
            check("wr1_data", {16'd0, wr_data_q[1]}, {16'd0, v.exp_d1});
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        corrupt_en   = 1'b0;
        corrupt_addr = '0;
        start        = 1'b0;
        base_addr    = '0;
        word_count   = '0;
        byte_in      = '0;
        byte_valid   = 1'b0;
        RST_N        = 1'b0;

        //          base      count   bytes          gap mid err n  d0        d1
        vecs[0] = '{15'd100,   15'd2, 32'h1234ABCD, 0, 0, 0, 2, 16'h1234, 16'hABCD};
        vecs[1] = '{15'd16383, 15'd2, 32'h00000000, 0, 0, 1, 0, 16'h0000, 16'h0000};
        vecs[2] = '{15'd50,    15'd0, 32'h00000000, 0, 0, 0, 0, 16'h0000, 16'h0000};
        vecs[3] = '{15'd16383, 15'd1, 32'h5AA50000, 0, 0, 0, 1, 16'h5AA5, 16'h0000};
        vecs[4] = '{15'd32767, 15'd1, 32'h00000000, 0, 0, 1, 0, 16'h0000, 16'h0000};
        vecs[5] = '{15'd0,     15'd1, 32'hFF000000, 0, 0, 0, 1, 16'hFF00, 16'h0000};
        vecs[6] = '{15'd16382, 15'd2, 32'h01020304, 0, 0, 0, 2, 16'h0102, 16'h0304};
        vecs[7] = '{15'd200,   15'd2, 32'hDEADBEEF, 3, 0, 0, 2, 16'hDEAD, 16'hBEEF};
        vecs[8] = '{15'd300,   15'd2, 32'hC0FFEE11, 0, 1, 0, 2, 16'hC0FF, 16'hEE11};

        #1;
        check("rst_busy",     {31'd0, busy},       32'd0);
        check("rst_done",     {31'd0, done},       32'd0);
        check("rst_error",    {31'd0, error},      32'd0);
        check("rst_ready",    {31'd0, byte_ready}, 32'd0);
        check("rst_load",     {31'd0, mem_load},   32'd0);
        check("rst_address",  {17'd0, mem_address}, 32'd0);
        check("rst_mem_in",   {16'd0, mem_in},     32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < int'(NVEC); i++) begin
            run_vec(vecs[i]);
        end

        // Reset while in LO_BYTE of the second word.
        wr_addr_q.delete();
        wr_data_q.delete();
        base_addr  = 15'd400;
        word_count = 15'd2;
        start      = 1'b1;
        @(negedge CLK);
        start      = 1'b0;
        feed_byte(8'h11, 1'b0);
        feed_byte(8'h22, 1'b0);
        feed_byte(8'h33, 1'b0);
        check("pre_rst_ready", {31'd0, byte_ready}, 32'd1);
        RST_N = 1'b0;
        #1;
        check("mid_rst_busy",    {31'd0, busy},        32'd0);
        check("mid_rst_ready",   {31'd0, byte_ready},  32'd0);
        check("mid_rst_load",    {31'd0, mem_load},    32'd0);
        check("mid_rst_address", {17'd0, mem_address}, 32'd0);
        check("mid_rst_mem_in",  {16'd0, mem_in},      32'd0);
        check("mid_rst_done",    {31'd0, done},        32'd0);
        check("mid_rst_error",   {31'd0, error},       32'd0);
        byte_in    = 8'h44;
        byte_valid = 1'b1;
        repeat (3) @(negedge CLK);
        byte_valid = 1'b0;
        RST_N      = 1'b1;
        repeat (3) @(negedge CLK);
        check("mid_rst_writes", wr_addr_q.size(), 32'd1);
        if (wr_addr_q.size() >= 1) begin
            check("mid_rst_wr0_addr", {17'd0, wr_addr_q[0]}, 32'd400);
            check("mid_rst_wr0_data", {16'd0, wr_data_q[0]}, 32'h1122);
        end
        run_vec(vecs[0]);

`ifdef MEM_LOADER_READBACK_EN
        // Word 1 of 3 reads back corrupted.
        wr_addr_q.delete();
        wr_data_q.delete();
        corrupt_en   = 1'b1;
        corrupt_addr = 15'd501;
        base_addr    = 15'd500;
        word_count   = 15'd3;
        start        = 1'b1;
        @(negedge CLK);
        start        = 1'b0;
        feed_byte(8'h01, 1'b0);
        feed_byte(8'h02, 1'b0);
        feed_byte(8'h03, 1'b0);
        feed_byte(8'h04, 1'b0);
        wait_done();
        corrupt_en = 1'b0;
        check("rb_error",  {31'd0, error}, 32'd1);
        check("rb_writes", wr_addr_q.size(), 32'd2);
        if (wr_addr_q.size() >= 2) begin
            check("rb_wr1_addr", {17'd0, wr_addr_q[1]}, 32'd501);
            check("rb_wr1_data", {16'd0, wr_data_q[1]}, 32'h0304);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
